// File: rtl/uart_tx_if.sv
// uart_tx_if: load handshake between a byte producer and the UART transmitter
interface uart_tx_if;
   logic [7:0] tx_data;
   logic       ld;
   logic       tdre;
   logic       OE;
   modport master (output tx_data, ld, input tdre, OE);
   modport slave (input tx_data, ld, output tdre, OE);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: double-buffered 8N1 serial transmitter with sticky overrun flag
module uart_tx #(
   parameter logic [11:0] BIT_TIME = 12'h514
) (
   input  logic       clk,
   input  logic       clr,
   uart_tx_if.slave   bus,
   output logic       TxD,
   output logic       busy
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] DATA  = 2'd2;
   localparam logic [1:0] STOP  = 2'd3;
   logic [1:0]  state_q, state_d;
   logic [7:0]  tx_buf_q, tx_buf_d;
   logic [7:0]  shreg_q, shreg_d;
   logic [11:0] baud_cnt_q, baud_cnt_d;
   logic [3:0]  bit_cnt_q, bit_cnt_d;
   logic        txd_q, txd_d;
   logic        tdre_q, tdre_d;
   logic        oe_q, oe_d;
   logic        bit_end;
   logic        xfer;
   assign bit_end  = baud_cnt_q == BIT_TIME - 12'd1;
   assign xfer     = !tdre_q && (state_q == IDLE || (state_q == STOP && bit_end));
   assign TxD      = txd_q;
   assign busy     = state_q != IDLE;
   assign bus.tdre = tdre_q;
   assign bus.OE   = oe_q;
   // next-state: buffer load/overrun, holding-to-shift transfer, bit sequencing
   always_comb begin
      state_d    = state_q;
      tx_buf_d   = tx_buf_q;
      shreg_d    = shreg_q;
      baud_cnt_d = baud_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      txd_d      = txd_q;
      tdre_d     = tdre_q;
      oe_d       = oe_q;
      if (bus.ld) begin
         tx_buf_d = tdre_q ? bus.tx_data : tx_buf_q;
         tdre_d   = tdre_q ? 1'b0 : tdre_q;
         oe_d     = !tdre_q;
      end
      if (state_q != IDLE)
         baud_cnt_d = bit_end ? 12'd0 : baud_cnt_q + 12'd1;
      if (xfer) begin
         shreg_d    = tx_buf_q;
         tdre_d     = 1'b1;
         txd_d      = 1'b0;
         baud_cnt_d = 12'd0;
         bit_cnt_d  = 4'd0;
         state_d    = START;
      end else if (bit_end && state_q == START) begin
         txd_d   = shreg_q[0];
         state_d = DATA;
      end else if (bit_end && state_q == DATA) begin
         shreg_d   = {1'b0, shreg_q[7:1]};
         bit_cnt_d = bit_cnt_q + 4'd1;
         txd_d     = (bit_cnt_q == 4'd7) ? 1'b1 : shreg_q[1];
         state_d   = (bit_cnt_q == 4'd7) ? STOP : DATA;
      end else if (bit_end && state_q == STOP) begin
         txd_d   = 1'b1;
         state_d = IDLE;
      end
   end
   // state registers, cleared asynchronously so a frame aborts with the line high
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q    <= IDLE;
         tx_buf_q   <= 8'd0;
         shreg_q    <= 8'd0;
         baud_cnt_q <= 12'd0;
         bit_cnt_q  <= 4'd0;
         txd_q      <= 1'b1;
         tdre_q     <= 1'b1;
         oe_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         tx_buf_q   <= tx_buf_d;
         shreg_q    <= shreg_d;
         baud_cnt_q <= baud_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         txd_q      <= txd_d;
         tdre_q     <= tdre_d;
         oe_q       <= oe_d;
      end
   end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed frame vectors and corner sequences for uart_tx at BIT_TIME=16
module tb_uart_tx;
   typedef struct {
      logic [7:0] data;
      logic [9:0] line;
   } frame_t;
   logic clk;
   logic clr;
   logic TxD;
   logic busy;
   int   errors;
   int   checks;
   frame_t vec[4];
   uart_tx_if bus ();
   uart_tx #(.BIT_TIME(12'd16)) dut (.clk(clk), .clr(clr), .bus(bus), .TxD(TxD), .busy(busy));
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
      bus.ld = 1'b0;
   endtask
   task automatic send(input logic [7:0] d);
      bus.tx_data = d;
      bus.ld = 1'b1;
      tick();
      chk("ld_tdre", 32'(bus.tdre), 32'd0);
      chk("ld_oe_clear", 32'(bus.OE), 32'd0);
      chk("ld_txd_still_high", 32'(TxD), 32'd1);
      tick();
      chk("start_txd", 32'(TxD), 32'd0);
      chk("start_tdre", 32'(bus.tdre), 32'd1);
      chk("start_busy", 32'(busy), 32'd1);
   endtask
   task automatic check_frame(input logic [9:0] line, input int n0, input int n1);
      for (int i = n0; i < n1; i++) begin
         chk($sformatf("frame_txd_bit%0d_cyc%0d", i / 16, i % 16), 32'(TxD), 32'(line[i / 16]));
         chk("frame_busy", 32'(busy), 32'd1);
         tick();
      end
   endtask
   task automatic idle_chk();
      chk("idle_txd", 32'(TxD), 32'd1);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_tdre", 32'(bus.tdre), 32'd1);
   endtask
   initial begin
      errors = 0;
      checks = 0;
      vec[0] = '{8'h55, 10'b1010101010};
      vec[1] = '{8'h00, 10'b1000000000};
      vec[2] = '{8'hFF, 10'b1111111110};
      vec[3] = '{8'hC6, 10'b1110001100};
      clr = 1'b1;
      bus.ld = 1'b0;
      bus.tx_data = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_txd", 32'(TxD), 32'd1);
      chk("rst_tdre", 32'(bus.tdre), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_oe", 32'(bus.OE), 32'd0);
      clr = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.tx_data = 8'hA5 ^ 8'(i);
         tick();
         idle_chk();
      end
      for (int v = 0; v < 4; v++) begin
         send(vec[v].data);
         check_frame(vec[v].line, 0, 160);
         idle_chk();
      end
      send(8'hA3);
      bus.tx_data = 8'h0F;
      bus.ld = 1'b1;
      check_frame(10'b1101000110, 0, 160);
      check_frame(10'b1000011110, 0, 160);
      idle_chk();
      send(8'h11);
      bus.tx_data = 8'h22;
      bus.ld = 1'b1;
      tick();
      chk("second_ld_tdre", 32'(bus.tdre), 32'd0);
      chk("second_ld_oe", 32'(bus.OE), 32'd0);
      bus.tx_data = 8'h33;
      bus.ld = 1'b1;
      tick();
      chk("overrun_oe", 32'(bus.OE), 32'd1);
      chk("overrun_tdre", 32'(bus.tdre), 32'd0);
      check_frame(10'b1000100010, 2, 160);
      check_frame(10'b1001000100, 0, 160);
      idle_chk();
      chk("oe_sticky", 32'(bus.OE), 32'd1);
      send(8'h5A);
      check_frame(10'b1010110100, 0, 160);
      idle_chk();
      bus.tx_data = 8'h3C;
      bus.ld = 1'b1;
      tick();
      chk("xfer_edge_tdre", 32'(bus.tdre), 32'd0);
      bus.tx_data = 8'hC3;
      bus.ld = 1'b1;
      tick();
      chk("xfer_edge_oe", 32'(bus.OE), 32'd1);
      chk("xfer_edge_txd", 32'(TxD), 32'd0);
      chk("xfer_edge_tdre", 32'(bus.tdre), 32'd1);
      check_frame(10'b1001111000, 0, 160);
      idle_chk();
      send(8'h55);
      check_frame(10'b1010101010, 0, 70);
      #2 clr = 1'b1;
      #1;
      chk("clr_txd", 32'(TxD), 32'd1);
      chk("clr_tdre", 32'(bus.tdre), 32'd1);
      chk("clr_busy", 32'(busy), 32'd0);
      chk("clr_oe", 32'(bus.OE), 32'd0);
      @(negedge clk);
      clr = 1'b0;
      for (int i = 0; i < 200; i++) begin
         bus.tx_data = 8'($urandom);
         tick();
         chk("post_clr_txd", 32'(TxD), 32'd1);
         chk("post_clr_busy", 32'(busy), 32'd0);
      end
      send(8'h81);
      check_frame(10'b1100000010, 0, 160);
      idle_chk();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
